// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction/data) arbiter in front of a single
// RAM port, with fair alternation on contention, access timeout and sticky
// error reporting.
//
// Ports:
//   CLK, RST                 clock, async active-high reset
//   iREN/iaddr               instruction read request and address
//   iload/iwait              instruction read data and stall
//   dREN/dWEN/daddr/dstore   data read/write request, address, write data
//   dload/dwait              data read data and stall
//   ramREN/ramWEN            RAM read/write strobes
//   ramaddr/ramstore         RAM address and write data
//   ramload/ramstate         RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   mem_err                  sticky error flag (timeout or RAM ERROR)
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;
    // Timeout fires on the cycle whose increment would make the count
    // reach TIMEOUT-1.
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 2);

    // last_grant: 0 = INST, 1 = DATA
    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic dreq;
    logic granted;
    logic req_g;
    logic done;
    logic fail;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign dreq    = dREN | dWEN;
    assign granted = (state_q != IDLE);
    assign req_g   = (state_q == INST) ? iREN : dreq;
    // A side that has dropped its request gets no completion.
    assign done    = granted & req_g & (ramstate == RS_ACCESS);
    assign fail    = granted & req_g & ~done
                   & ((ramstate == RS_ERROR) | (cnt_q == CNT_LAST));

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;

        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (dreq && iREN) begin
                    state_d = last_q ? INST : DATA;
                end else if (dreq) begin
                    state_d = DATA;
                end else if (iREN) begin
                    state_d = INST;
                end
            end
            INST: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (done) begin
                    iload = ramload;
                end
            end
            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = ~dWEN;
                if (done && !dWEN) begin
                    dload = ramload;
                end
            end
            default: state_d = IDLE;
        endcase

        if (granted) begin
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (!req_g) begin
                state_d = IDLE;
            end else if (done || fail) begin
                state_d = IDLE;
                last_d  = (state_q == DATA);
                err_d   = err_q | fail;
            end
        end
    end

    assign iwait   = iREN & ~((state_q == INST) & (ramstate == RS_ACCESS));
    assign dwait   = dreq & ~((state_q == DATA) & (ramstate == RS_ACCESS));
    assign mem_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
// (default parameters, TIMEOUT=16).
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [1:0]  ramstate;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic c1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic c32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(negedge CLK);
    endtask

    initial begin
        logic dside;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'b00;
        #1;
        c1("rst_ren", ramREN, 1'b0);
        c1("rst_wen", ramWEN, 1'b0);
        c32("rst_addr", ramaddr, 32'h0);
        c1("rst_err", mem_err, 1'b0);
        iREN = 1;
        #1;
        c1("rst_iwait", iwait, 1'b1);
        c32("rst_iload", iload, 32'h0);
        iREN = 0;
        nxt; RST = 0;

        // single instruction fetch, ACCESS one cycle after grant
        nxt; iREN = 1; iaddr = 32'h40;
        #1;
        c1("i_idle_wait", iwait, 1'b1);
        c1("i_idle_ren", ramREN, 1'b0);
        nxt; ramstate = 2'b10; ramload = 32'h8C010004;
        #1;
        c1("i_ren", ramREN, 1'b1);
        c32("i_addr", ramaddr, 32'h40);
        c1("i_wait_low", iwait, 1'b0);
        c32("i_load", iload, 32'h8C010004);
        c32("i_store", ramstore, 32'h0);
        nxt; iREN = 0; ramstate = 2'b00;
        #1;
        c1("i_back_idle", ramREN, 1'b0);
        c32("i_load_clr", iload, 32'h0);

        // sustained contention: D, I, D, I
        iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            nxt; ramstate = 2'b10; ramload = 32'h1000 + k;
            dside = (k % 2 == 0);
            #1;
            c32("alt_addr", ramaddr, dside ? 32'h200 : 32'h44);
            c1("alt_iwait", iwait, dside);
            c1("alt_dwait", dwait, !dside);
            c32("alt_dload", dload, dside ? 32'h1000 + k : 32'h0);
            c32("alt_iload", iload, dside ? 32'h0 : 32'h1000 + k);
            nxt; ramstate = 2'b00;
            #1;
            c1("alt_idle", ramREN, 1'b0);
        end
        iREN = 0; dREN = 0;

        // write beats read, address passes through mid-grant
        dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        nxt; ramstate = 2'b01;
        #1;
        c1("w_wen", ramWEN, 1'b1);
        c1("w_ren", ramREN, 1'b0);
        c32("w_addr", ramaddr, 32'h100);
        c32("w_store", ramstore, 32'hDEADBEEF);
        c1("w_busy_wait", dwait, 1'b1);
        daddr = 32'h104;
        #1;
        c32("w_addr_pass", ramaddr, 32'h104);
        nxt; ramstate = 2'b10; ramload = 32'h55;
        #1;
        c1("w_done", dwait, 1'b0);
        c32("w_dload0", dload, 32'h0);
        nxt; dREN = 0; dWEN = 0; ramstate = 2'b00;
        #1;
        c1("w_idle", ramWEN, 1'b0);

        // timeout after 15 BUSY cycles
        dREN = 1; daddr = 32'h300;
        nxt; ramstate = 2'b01;
        for (int i = 0; i < 15; i++) begin
            #1;
            c1("to_ren", ramREN, 1'b1);
            c1("to_err0", mem_err, 1'b0);
            nxt;
        end
        #1;
        c1("to_err1", mem_err, 1'b1);
        c1("to_idle", ramREN, 1'b0);
        dREN = 0;

        // error is sticky across a good access
        iREN = 1; iaddr = 32'h48;
        nxt; ramstate = 2'b10; ramload = 32'hA5A5;
        #1;
        c32("post_iload", iload, 32'hA5A5);
        c1("post_err", mem_err, 1'b1);
        nxt; iREN = 0; ramstate = 2'b00;
        #1;
        c1("post_err2", mem_err, 1'b1);

        // reset mid-access
        dREN = 1; daddr = 32'h400;
        nxt; ramstate = 2'b01;
        #1;
        c1("mr_ren", ramREN, 1'b1);
        #2; RST = 1;
        #1;
        c1("mr_ren0", ramREN, 1'b0);
        c32("mr_addr0", ramaddr, 32'h0);
        c1("mr_err0", mem_err, 1'b0);
        c1("mr_dwait", dwait, 1'b1);
        iREN = 1; iaddr = 32'h4C;
        nxt; RST = 0;
        #1;
        c1("mr_idle", ramREN, 1'b0);
        nxt; ramstate = 2'b10; ramload = 32'h77;
        #1;
        c32("mr_dfirst", ramaddr, 32'h400);
        c32("mr_dload", dload, 32'h77);
        c1("mr_iwait", iwait, 1'b1);

        // INST grant hits ERROR, pending data goes next
        nxt; daddr = 32'h500; ramstate = 2'b00;
        #1;
        c1("er_idle", ramREN, 1'b0);
        nxt; ramstate = 2'b11;
        #1;
        c32("er_iaddr", ramaddr, 32'h4C);
        c1("er_iwait", iwait, 1'b1);
        c32("er_iload", iload, 32'h0);
        c1("er_err0", mem_err, 1'b0);
        nxt; ramstate = 2'b00;
        #1;
        c1("er_err1", mem_err, 1'b1);
        c1("er_idle2", ramREN, 1'b0);
        nxt; ramstate = 2'b10; ramload = 32'h99;
        #1;
        c32("er_dnext", ramaddr, 32'h500);
        c32("er_dload", dload, 32'h99);
        nxt; dREN = 0; ramstate = 2'b00;

        // abort leaves last_grant (DATA) unchanged
        nxt; ramstate = 2'b01;
        #1;
        c1("ab_ren", ramREN, 1'b1);
        iREN = 0;
        #1;
        c1("ab_iwait", iwait, 1'b0);
        c32("ab_iload", iload, 32'h0);
        nxt;
        #1;
        c1("ab_idle", ramREN, 1'b0);
        iREN = 1; dREN = 1;
        nxt;
        #1;
        c32("ab_inst_wins", ramaddr, 32'h4C);
        iREN = 0; dREN = 0;
        nxt;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
